mtsp_mem_cmd_arbiter: RTL and testbench

Parametrised N-channel memory command front end for the MTSP processor, one generation beyond the fixed two-source version. It arbitrates between `NUM_CH` descriptor sources using fixed-priority or round-robin selection. It computes physical and global addresses in a stall-aware 3-stage pipeline and issues one command per cycle to the bus bridge. An optional cache look-up table decides between master and cache routing.

---
 rtl/mtsp_mem_cmd_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mtsp_mem_cmd_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_mem_cmd_arbiter.sv
// rtl/mtsp_mem_cmd_arbiter.sv - N-channel memory command arbiter with stall-aware address pipeline
// Optional direct-mapped cache tag LUT: define MTSP_MEMCMD_CACHE_LUT_EN.
module mtsp_mem_cmd_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 1,
  parameter int GADDR_W  = 20,
  parameter int LUT_AW   = 6
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_CH-1:0]         CH_REQ,
  input  logic [NUM_CH*128-1:0]     CH_DESC,
  output logic [NUM_CH-1:0]         CH_ACK,
  input  logic                      LUT_CLEAR,
  output logic                      M_VALID,
  input  logic                      M_READY,
  output logic [$clog2(NUM_CH)-1:0] M_CH,
  output logic                      M_WE,
  output logic [7:0]                M_SIZE,
  output logic [31:0]               M_PADDR,
  output logic [GADDR_W-1:0]        M_GADDR,
  output logic                      M_REQ_MASTER,
  output logic                      M_REQ_CACHE,
  output logic                      CACHE_HIT
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            we, cen, conly;
    logic [15:0]     id;
    logic [7:0]      stride, size;
    logic [15:0]     mask;
    logic [31:0]     pbase, gbase;
  } s0_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            we, cen, conly;
    logic [7:0]      size;
    logic [31:0]     pbase, gbase;
    logic [23:0]     poff, goff;
  } s1_t;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic               we;
    logic [7:0]         size;
    logic [31:0]        paddr;
    logic [GADDR_W-1:0] gaddr;
    logic               master, cache, hit;
  } cmd_t;

  logic [CH_W-1:0] rr, grant_idx;
  logic            grant_any, grant;
  int              cand;
  logic [127:0]    sel_desc;
  logic [12:0]     unused_rsvd;

  s0_t  s0_q;
  s1_t  s1_q;
  cmd_t s2_cmd, out_cmd, skid_cmd;
  logic s0_valid, s1_valid, out_valid, skid_valid, out_first;
  logic s0_free, s0_adv, s1_free, s1_adv, s2_null;
  logic out_fire, out_load, skid_load, skid_to_out;
  logic [31:0] s2_paddr;
  logic        lut_hit;

  // Fixed mode scans from channel 0; round-robin scans from rr.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (ARB_MODE != 0) ? (int'(rr) + k) % NUM_CH : k;
      if (!grant_any && CH_REQ[cand]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(cand);
      end
    end
  end

  assign out_fire    = out_valid && M_READY;
  assign s2_null     = (s1_q.size == 8'd0);
  assign s1_adv      = s1_valid && (s2_null || !skid_valid);
  assign s1_free     = !s1_valid || s1_adv;
  assign s0_adv      = s0_valid && s1_free;
  assign s0_free     = !s0_valid || s0_adv;
  assign grant       = grant_any && s0_free && nRST;
  assign out_load    = s1_adv && !s2_null && (!out_valid || out_fire);
  assign skid_load   = s1_adv && !s2_null && out_valid && !out_fire;
  assign skid_to_out = skid_valid && out_fire;

  always_comb begin
    CH_ACK = '0;
    if (grant) CH_ACK[grant_idx] = 1'b1;
  end

  assign sel_desc    = CH_DESC[{grant_idx, 7'd0} +: 128];
  assign unused_rsvd = sel_desc[124:112];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr       <= '0;
      s0_valid <= 1'b0;
      s0_q     <= '0;
    end else begin
      if (grant && ARB_MODE != 0)
        rr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      if (s0_free) begin
        s0_valid <= grant;
        if (grant) begin
          s0_q.ch     <= grant_idx;
          s0_q.we     <= sel_desc[127];
          s0_q.cen    <= sel_desc[126];
          s0_q.conly  <= sel_desc[125];
          s0_q.id     <= sel_desc[111:96];
          s0_q.stride <= sel_desc[95:88];
          s0_q.size   <= sel_desc[87:80];
          s0_q.mask   <= sel_desc[79:64];
          s0_q.pbase  <= sel_desc[63:32];
          s0_q.gbase  <= sel_desc[31:0];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_free) begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_q.ch    <= s0_q.ch;
        s1_q.we    <= s0_q.we;
        s1_q.cen   <= s0_q.cen;
        s1_q.conly <= s0_q.conly;
        s1_q.size  <= s0_q.size;
        s1_q.pbase <= s0_q.pbase;
        s1_q.gbase <= s0_q.gbase;
        s1_q.poff  <= 24'(s0_q.stride) * 24'(s0_q.id);
        s1_q.goff  <= 24'(s0_q.size) * 24'(s0_q.id & s0_q.mask);
      end
    end
  end

  assign s2_paddr = s1_q.pbase + {8'd0, s1_q.poff};

  always_comb begin
    s2_cmd        = '0;
    s2_cmd.ch     = s1_q.ch;
    s2_cmd.we     = s1_q.we;
    s2_cmd.size   = s1_q.size;
    s2_cmd.paddr  = s2_paddr;
    s2_cmd.gaddr  = GADDR_W'(s1_q.gbase + {8'd0, s1_q.goff});
    s2_cmd.master = 1'b1;
    if (s1_q.conly) begin
      s2_cmd.master = 1'b0;
      s2_cmd.cache  = 1'b1;
    end else if (s1_q.cen) begin
      s2_cmd.cache = 1'b1;
      if (lut_hit && !s1_q.we) begin
        s2_cmd.master = 1'b0;
        s2_cmd.hit    = 1'b1;
      end
    end
  end

  // Skid slot absorbs one S2 result while the output is held, so S1 can drain.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_cmd    <= '0;
      skid_valid <= 1'b0;
      skid_cmd   <= '0;
    end else begin
      out_first <= 1'b0;
      if (skid_to_out) begin
        out_cmd    <= skid_cmd;
        out_valid  <= 1'b1;
        out_first  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (out_load) begin
        out_cmd   <= s2_cmd;
        out_valid <= 1'b1;
        out_first <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (skid_load) begin
        skid_cmd   <= s2_cmd;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef MTSP_MEMCMD_CACHE_LUT_EN
  localparam int LUT_N = 1 << LUT_AW;
  localparam int TAG_W = 26 - LUT_AW;

  logic [LUT_N-1:0]  lut_valid;
  logic [TAG_W-1:0]  lut_tag [LUT_N];
  logic [LUT_AW-1:0] lut_idx;
  logic [TAG_W-1:0]  lut_key;
  logic              lut_alloc;

  assign lut_idx   = s2_paddr[LUT_AW+5:6];
  assign lut_key   = s2_paddr[31:LUT_AW+6];
  assign lut_hit   = lut_valid[lut_idx] && (lut_tag[lut_idx] == lut_key) && !LUT_CLEAR;
  // Only LUT-routed misses and writes carry both master and cache.
  assign lut_alloc = (out_load || skid_load) && s2_cmd.master && s2_cmd.cache && !LUT_CLEAR;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          lut_valid <= '0;
    else if (LUT_CLEAR) lut_valid <= '0;
    else if (lut_alloc) lut_valid[lut_idx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (lut_alloc) lut_tag[lut_idx] <= lut_key;
  end
`else
  logic unused_lut_clear;
  assign unused_lut_clear = LUT_CLEAR;
  assign lut_hit          = 1'b0;
`endif

  assign M_VALID      = out_valid;
  assign M_CH         = out_cmd.ch;
  assign M_WE         = out_cmd.we;
  assign M_SIZE       = out_cmd.size;
  assign M_PADDR      = out_cmd.paddr;
  assign M_GADDR      = out_cmd.gaddr;
  assign M_REQ_MASTER = out_cmd.master;
  assign M_REQ_CACHE  = out_cmd.cache;
  assign CACHE_HIT    = out_valid && out_first && out_cmd.hit;

endmodule

// File: tb/tb_mtsp_mem_cmd_arbiter.sv
// tb/tb_mtsp_mem_cmd_arbiter.sv - directed self-checking bench for mtsp_mem_cmd_arbiter
module tb_mtsp_mem_cmd_arbiter;
  logic         CLK = 1'b0;
  logic         nRST;
  logic [3:0]   CH_REQ;
  logic [511:0] CH_DESC;
  logic         LUT_CLEAR, M_READY;

  logic [3:0]  ack_rr, ack_fp;
  logic        mv_rr, we_rr, ms_rr, ca_rr, hit_rr;
  logic [1:0]  ch_rr;
  logic [7:0]  size_rr;
  logic [31:0] pa_rr;
  logic [19:0] ga_rr;
  logic        unused_fp_mv, unused_fp_we, unused_fp_ms, unused_fp_ca, unused_fp_hit;
  logic [1:0]  unused_fp_ch;
  logic [7:0]  unused_fp_size;
  logic [31:0] unused_fp_pa;
  logic [19:0] unused_fp_ga;

  int errors = 0;
  int checks = 0;
  logic [31:0] pexp [4] = '{32'h0000_0002, 32'h0001_0004, 32'h0002_0006, 32'h0003_0008};

  always #5 CLK = ~CLK;

  mtsp_mem_cmd_arbiter #(.NUM_CH(4), .ARB_MODE(1), .GADDR_W(20), .LUT_AW(6)) dut_rr (
    .CLK(CLK), .nRST(nRST), .CH_REQ(CH_REQ), .CH_DESC(CH_DESC), .CH_ACK(ack_rr),
    .LUT_CLEAR(LUT_CLEAR), .M_VALID(mv_rr), .M_READY(M_READY), .M_CH(ch_rr), .M_WE(we_rr),
    .M_SIZE(size_rr), .M_PADDR(pa_rr), .M_GADDR(ga_rr), .M_REQ_MASTER(ms_rr),
    .M_REQ_CACHE(ca_rr), .CACHE_HIT(hit_rr));

  mtsp_mem_cmd_arbiter #(.NUM_CH(4), .ARB_MODE(0), .GADDR_W(20), .LUT_AW(6)) dut_fp (
    .CLK(CLK), .nRST(nRST), .CH_REQ(CH_REQ), .CH_DESC(CH_DESC), .CH_ACK(ack_fp),
    .LUT_CLEAR(LUT_CLEAR), .M_VALID(unused_fp_mv), .M_READY(M_READY), .M_CH(unused_fp_ch),
    .M_WE(unused_fp_we), .M_SIZE(unused_fp_size), .M_PADDR(unused_fp_pa), .M_GADDR(unused_fp_ga),
    .M_REQ_MASTER(unused_fp_ms), .M_REQ_CACHE(unused_fp_ca), .CACHE_HIT(unused_fp_hit));

  function automatic logic [127:0] make_desc(input logic we, input logic cen, input logic conly,
      input logic [15:0] id, input logic [7:0] stride, input logic [7:0] size,
      input logic [15:0] mask, input logic [31:0] pbase, input logic [31:0] gbase);
    return {we, cen, conly, 13'd0, id, stride, size, mask, pbase, gbase};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; CH_REQ = '0; LUT_CLEAR = 1'b0; M_READY = 1'b1;
    step(); step();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic set_all_desc();
    for (int i = 0; i < 4; i++)
      CH_DESC[i*128 +: 128] = make_desc(1'b0, 1'b0, 1'b0, 16'(i + 1), 8'd2, 8'd8, 16'hFFFF,
                                        32'(i) << 16, 32'h0);
  endtask

  task automatic issue_one(input int ch, input logic [127:0] d, output logic ok,
      output logic ms, output logic ca, output logic h, output logic h_next);
    step();
    CH_DESC[ch*128 +: 128] = d;
    CH_REQ = 4'b0001 << ch;
    @(negedge CLK);
    step();
    CH_REQ = '0;
    ok = 1'b0; ms = 1'b0; ca = 1'b0; h = 1'b0; h_next = 1'b0;
    for (int k = 0; k < 6 && !ok; k++) begin
      @(negedge CLK);
      if (mv_rr) begin
        ok = 1'b1; ms = ms_rr; ca = ca_rr; h = hit_rr;
      end else begin
        step();
      end
    end
    step();
    @(negedge CLK);
    h_next = hit_rr;
  endtask

  task automatic test_reset();
    nRST = 1'b0; CH_REQ = 4'hF; CH_DESC = '0; LUT_CLEAR = 1'b0; M_READY = 1'b1;
    #2;
    checks++; if (ack_rr !== 4'h0) begin errors++; $display("FAIL reset_ack_rr: got %h want 0", ack_rr); end
    checks++; if (ack_fp !== 4'h0) begin errors++; $display("FAIL reset_ack_fp: got %h want 0", ack_fp); end
    checks++; if (mv_rr !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mv_rr); end
    checks++; if ({ms_rr, ca_rr, hit_rr, we_rr} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {ms_rr, ca_rr, hit_rr, we_rr}); end
    checks++; if ({ch_rr, size_rr} !== 10'd0) begin errors++; $display("FAIL reset_ch_size: got %h want 0", {ch_rr, size_rr}); end
    checks++; if ({pa_rr, ga_rr} !== 52'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", {pa_rr, ga_rr}); end
    CH_REQ = '0;
    step();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_single();
    step();
    CH_DESC[2*128 +: 128] = make_desc(1'b0, 1'b0, 1'b0, 16'd3, 8'd4, 8'd16, 16'hFFFF, 32'h1000, 32'h200);
    CH_REQ = 4'b0100;
    @(negedge CLK);
    checks++; if (ack_rr !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack_rr); end
    step(); CH_REQ = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      @(negedge CLK);
      checks++; if (mv_rr !== (k == 3)) begin errors++; $display("FAIL single_valid_t%0d: got %b want %b", k, mv_rr, (k == 3)); end
      if (k == 3) begin
        checks++; if (pa_rr !== 32'h100C) begin errors++; $display("FAIL single_paddr: got %h want 100c", pa_rr); end
        checks++; if (ga_rr !== 20'h230) begin errors++; $display("FAIL single_gaddr: got %h want 230", ga_rr); end
        checks++; if ({ms_rr, ca_rr, ch_rr, size_rr, we_rr} !== {1'b1, 1'b0, 2'd2, 8'd16, 1'b0}) begin
          errors++; $display("FAIL single_fields: got m%b c%b ch%0d sz%0d we%b want m1 c0 ch2 sz16 we0", ms_rr, ca_rr, ch_rr, size_rr, we_rr);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_ack;
    do_reset();
    set_all_desc();
    for (int k = 0; k < 8; k++) begin
      step();
      CH_REQ = (k < 5) ? 4'hF : 4'h0;
      @(negedge CLK);
      if (k < 5) begin
        exp_ack = 4'b0001 << (k % 4);
        checks++; if (ack_rr !== exp_ack) begin errors++; $display("FAIL rr_ack_%0d: got %b want %b", k, ack_rr, exp_ack); end
        checks++; if (ack_fp !== 4'b0001) begin errors++; $display("FAIL fp_ack_%0d: got %b want 0001", k, ack_fp); end
      end
      if (k >= 3) begin
        checks++;
        if (mv_rr !== 1'b1 || ch_rr !== 2'((k - 3) % 4) || pa_rr !== pexp[(k - 3) % 4]) begin
          errors++; $display("FAIL rr_issue_%0d: got v%b ch%0d pa %h want v1 ch%0d pa %h", k, mv_rr, ch_rr, pa_rr, (k - 3) % 4, pexp[(k - 3) % 4]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int acks;
    int n;
    logic [1:0]  got_ch [8];
    logic [31:0] got_pa [8];
    acks = 0; n = 0;
    do_reset();
    set_all_desc();
    for (int k = 0; k < 10; k++) begin
      step();
      CH_REQ = 4'hF; M_READY = 1'b0;
      @(negedge CLK);
      if (ack_rr != 4'h0) acks++;
      checks++;
      if (ack_rr !== ((k < 4) ? (4'b0001 << k) : 4'b0000)) begin
        errors++; $display("FAIL stall_ack_%0d: got %b want %b", k, ack_rr, (k < 4) ? (4'b0001 << k) : 4'b0000);
      end
      if (k >= 3) begin
        checks++;
        if (mv_rr !== 1'b1 || ch_rr !== 2'd0 || pa_rr !== pexp[0]) begin
          errors++; $display("FAIL stall_hold_%0d: got v%b ch%0d pa %h want v1 ch0 pa %h", k, mv_rr, ch_rr, pa_rr, pexp[0]);
        end
      end
    end
    checks++; if (acks != 4) begin errors++; $display("FAIL stall_ack_count: got %0d want 4", acks); end
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin CH_REQ = '0; M_READY = 1'b1; end
      @(negedge CLK);
      if (mv_rr && n < 8) begin got_ch[n] = ch_rr; got_pa[n] = pa_rr; n++; end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL stall_drain_count: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (got_ch[i] !== 2'(i) || got_pa[i] !== pexp[i]) begin
        errors++; $display("FAIL stall_drain_%0d: got ch%0d pa %h want ch%0d pa %h", i, got_ch[i], got_pa[i], i, pexp[i]);
      end
    end
  endtask

  task automatic test_lut();
    logic [127:0] d;
    logic ok, ms, ca, h, hn;
    d = make_desc(1'b0, 1'b1, 1'b0, 16'd0, 8'd4, 8'd4, 16'hFFFF, 32'h8000, 32'h0);
    issue_one(0, d, ok, ms, ca, h, hn);
    checks++; if ({ok, ms, ca, h} !== 4'b1110) begin errors++; $display("FAIL lut_first: got ok%b m%b c%b hit%b want ok1 m1 c1 hit0", ok, ms, ca, h); end
    issue_one(0, d, ok, ms, ca, h, hn);
`ifdef MTSP_MEMCMD_CACHE_LUT_EN
    checks++; if ({ok, ms, ca, h} !== 4'b1011) begin errors++; $display("FAIL lut_second: got ok%b m%b c%b hit%b want ok1 m0 c1 hit1", ok, ms, ca, h); end
    checks++; if (hn !== 1'b0) begin errors++; $display("FAIL lut_hit_pulse: got %b want 0 one cycle later", hn); end
`else
    checks++; if ({ok, ms, ca, h} !== 4'b1110) begin errors++; $display("FAIL lut_second: got ok%b m%b c%b hit%b want ok1 m1 c1 hit0", ok, ms, ca, h); end
`endif
    step(); LUT_CLEAR = 1'b1;
    step(); LUT_CLEAR = 1'b0;
    issue_one(0, d, ok, ms, ca, h, hn);
    checks++; if ({ok, ms, ca, h} !== 4'b1110) begin errors++; $display("FAIL lut_after_clear: got ok%b m%b c%b hit%b want ok1 m1 c1 hit0", ok, ms, ca, h); end
  endtask

  task automatic test_null();
    step();
    CH_DESC[0 +: 128]   = make_desc(1'b0, 1'b0, 1'b0, 16'd1, 8'd4, 8'd0, 16'hFFFF, 32'h9000, 32'h0);
    CH_DESC[128 +: 128] = make_desc(1'b0, 1'b0, 1'b0, 16'd2, 8'd8, 8'd4, 16'hFFFF, 32'h4000, 32'h100);
    CH_REQ = 4'b0001;
    @(negedge CLK);
    checks++; if (ack_rr !== 4'b0001) begin errors++; $display("FAIL null_ack0: got %b want 0001", ack_rr); end
    step(); CH_REQ = 4'b0010;
    @(negedge CLK);
    checks++; if (ack_rr !== 4'b0010) begin errors++; $display("FAIL null_ack1: got %b want 0010", ack_rr); end
    step(); CH_REQ = '0;
    for (int k = 2; k < 7; k++) begin
      if (k > 2) step();
      @(negedge CLK);
      checks++; if (mv_rr !== (k == 4)) begin errors++; $display("FAIL null_valid_t%0d: got %b want %b", k, mv_rr, (k == 4)); end
      if (k == 4) begin
        checks++;
        if (ch_rr !== 2'd1 || pa_rr !== 32'h4010 || ga_rr !== 20'h108) begin
          errors++; $display("FAIL null_second: got ch%0d pa %h ga %h want ch1 pa 4010 ga 108", ch_rr, pa_rr, ga_rr);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_all_desc();
    for (int k = 0; k < 3; k++) begin
      step(); CH_REQ = 4'hF;
      @(negedge CLK);
    end
    step(); #1;
    checks++; if (mv_rr !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b want 1", mv_rr); end
    nRST = 1'b0;
    #1;
    checks++; if (ack_rr !== 4'h0 || mv_rr !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl: got ack %b v%b want 0000 v0", ack_rr, mv_rr); end
    checks++;
    if ({ch_rr, size_rr, pa_rr, ga_rr, ms_rr, ca_rr, hit_rr, we_rr} !== '0) begin
      errors++; $display("FAIL mid_reset_data: got ch%0d sz%0d pa %h ga %h m%b c%b h%b we%b want all 0", ch_rr, size_rr, pa_rr, ga_rr, ms_rr, ca_rr, hit_rr, we_rr);
    end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++; if (ack_rr !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart: got %b want 0001", ack_rr); end
    step(); CH_REQ = '0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      @(negedge CLK);
      checks++; if (mv_rr !== (k == 3)) begin errors++; $display("FAIL mid_post_valid_t%0d: got %b want %b", k, mv_rr, (k == 3)); end
      if (k == 3) begin
        checks++;
        if (ch_rr !== 2'd0 || pa_rr !== pexp[0]) begin
          errors++; $display("FAIL mid_post_cmd: got ch%0d pa %h want ch0 pa %h", ch_rr, pa_rr, pexp[0]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_stall();
    test_lut();
    test_null();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
